// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates a single byte-wide memory port between the
// instruction-fetch requester and the MEM-stage data requester. Multi-byte
// accesses are split into little-endian byte beats; reads are reassembled and
// sign/zero-extended, and each requester gets a one-cycle done pulse.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rdy_in          global enable; low freezes all state and masks mem_wr
//   if_*            fetch request/address in, done pulse and instruction out
//   data_*          load/store request, size, signedness, address, store data
//                   in; done pulse and extended load result out
//   mem_*           byte bus: mem_a address, mem_dout/mem_wr write, mem_din
//                   read data (valid the cycle after its address)
//   busy            controller is mid-access
//
// Build option
//   MEM_CTRL_FAIR_EN  when defined, contested grants alternate between the two
//                     requesters; otherwise DATA always beats IF.
module mem_access_ctrl #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [LEN-1:0]        if_inst,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic                  data_unsigned,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LEN-1:0]        data_wdata,
  output logic                  data_done,
  output logic [LEN-1:0]        data_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  is_data_q, is_data_d;
  logic                  uns_q, uns_d;
  logic [1:0]            size_q, size_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [LEN-1:0]        buf_q, buf_d;
  logic [LEN-1:0]        if_inst_q, if_inst_d;
  logic [LEN-1:0]        data_rdata_q, data_rdata_d;
  logic                  if_done_q, if_done_d;
  logic                  data_done_q, data_done_d;

  logic                  grant_data, grant_if;
  logic [1:0]            cap_idx;
  logic [LEN-1:0]        asm_word, ext_word;

  function automatic logic [2:0] size_to_n(input logic [1:0] s);
    case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

`ifdef MEM_CTRL_FAIR_EN
  logic last_data_q, last_data_d;  // 1: DATA won the most recent contested grant

  always_comb begin
    last_data_d = last_data_q;
    if (data_req && if_req) begin
      grant_data = ~last_data_q;
      grant_if   = last_data_q;
    end else begin
      grant_data = data_req;
      grant_if   = if_req;
    end
    // Only a contested grant that actually happens moves the pointer.
    if (state_q == StIdle && !if_done_q && !data_done_q && data_req && if_req) begin
      last_data_d = grant_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else if (rdy_in) begin
      last_data_q <= last_data_d;
    end
  end
`else
  assign grant_data = data_req;
  assign grant_if   = if_req & ~data_req;
`endif

  // In READ, counter value k captures byte k-1 (address issued the cycle before).
  assign cap_idx = 2'(cnt_q - 3'd1);

  always_comb begin
    asm_word = buf_q;
    asm_word[8*cap_idx +: 8] = mem_din;
  end

  always_comb begin
    case (size_q)
      2'b00:   ext_word = uns_q ? {{(LEN-8){1'b0}}, asm_word[7:0]}
                                : {{(LEN-8){asm_word[7]}}, asm_word[7:0]};
      2'b01:   ext_word = uns_q ? {{(LEN-16){1'b0}}, asm_word[15:0]}
                                : {{(LEN-16){asm_word[15]}}, asm_word[15:0]};
      default: ext_word = asm_word;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    base_d       = base_q;
    is_data_d    = is_data_q;
    uns_d        = uns_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    if_inst_d    = if_inst_q;
    data_rdata_d = data_rdata_q;
    if_done_d    = 1'b0;
    data_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The done cycle is a bubble so the finishing requester can drop req.
        if (!if_done_q && !data_done_q) begin
          if (grant_data) begin
            state_d   = data_we ? StWrite : StRead;
            base_d    = data_addr;
            n_d       = size_to_n(data_size);
            is_data_d = 1'b1;
            uns_d     = data_unsigned;
            size_d    = data_size;
            wdata_d   = data_wdata;
            cnt_d     = 3'd0;
            buf_d     = '0;
          end else if (grant_if) begin
            state_d   = StRead;
            base_d    = if_addr;
            n_d       = 3'd4;
            is_data_d = 1'b0;
            cnt_d     = 3'd0;
            buf_d     = '0;
          end
        end
      end
      StRead: begin
        if (cnt_q != 3'd0) buf_d = asm_word;
        if (cnt_q == n_q) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
          if (is_data_q) begin
            data_done_d  = 1'b1;
            data_rdata_d = ext_word;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = asm_word;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: begin
        if (cnt_q == n_q - 3'd1) begin
          state_d     = StIdle;
          cnt_d       = 3'd0;
          data_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if ((state_q == StRead && cnt_q < n_q) || state_q == StWrite) begin
      mem_a = base_q + ADDR_WIDTH'(cnt_q);  // wraps modulo 2^ADDR_WIDTH
    end
    if (state_q == StWrite) begin
      mem_dout = wdata_q[8*cnt_q[1:0] +: 8];
      mem_wr   = rdy_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      n_q          <= '0;
      base_q       <= '0;
      is_data_q    <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      if_inst_q    <= '0;
      data_rdata_q <= '0;
      if_done_q    <= 1'b0;
      data_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      base_q       <= base_d;
      is_data_q    <= is_data_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      if_inst_q    <= if_inst_d;
      data_rdata_q <= data_rdata_d;
      if_done_q    <= if_done_d;
      data_done_q  <= data_done_d;
    end
  end

  assign if_done    = if_done_q;
  assign if_inst    = if_inst_q;
  assign data_done  = data_done_q;
  assign data_rdata = data_rdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-addressed memory model sits on
// the bus, a reference memory image predicts load results and done cycles,
// and a negedge monitor pops expectations whenever a done pulse appears.
module tb_mem_access_ctrl;
  localparam int LEN = 32;
  localparam int AW  = 17;
  localparam int MSZ = 1 << AW;

  logic            clk = 1'b0;
  logic            rst, rdy_in;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_done;
  logic [LEN-1:0]  if_inst;
  logic            data_req, data_we, data_unsigned;
  logic [1:0]      data_size;
  logic [AW-1:0]   data_addr;
  logic [LEN-1:0]  data_wdata;
  logic            data_done;
  logic [LEN-1:0]  data_rdata;
  logic [7:0]      mem_din = 8'h00;
  logic [7:0]      mem_dout;
  logic [AW-1:0]   mem_a;
  logic            mem_wr;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] mem [MSZ];
  logic [7:0] ref_mem [MSZ];

  typedef struct {
    bit          we;
    int          n;
    int          addr;
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t dq[$];

  mem_access_ctrl #(.LEN(LEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .data_req(data_req), .data_we(data_we), .data_size(data_size),
    .data_unsigned(data_unsigned), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_wr === 1'b1) mem[mem_a] <= mem_dout;
    if (rdy_in) mem_din <= mem[mem_a];
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int wrap(int a);
    return a % MSZ;
  endfunction

  function automatic int nbytes(logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  // Little-endian gather from the reference image, then extension by arithmetic.
  function automatic logic [31:0] model_load(bit is_if, logic [1:0] size, bit uns, int addr);
    int     n;
    longint v;
    n = is_if ? 4 : nbytes(size);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[wrap(addr + i)]) << (8 * i);
    if (!is_if && !uns && n == 1) v = (v ^ 'h80) - 'h80;
    if (!is_if && !uns && n == 2) v = (v ^ 'h8000) - 'h8000;
    return v[31:0];
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (if_done === 1'b1) begin
      if (if_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL if_done_unexpected: if_done=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = if_q.pop_front();
        check("if_inst", if_inst, e.val);
        check("if_done_cycle", cyc, e.due);
      end
    end
    if (data_done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL data_done_unexpected: data_done=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = dq.pop_front();
        if (e.we) begin
          for (int i = 0; i < e.n; i++) begin
            check("store_byte", 32'(mem[wrap(e.addr + i)]), 32'(e.val[8*i +: 8]));
          end
        end else begin
          check("data_rdata", data_rdata, e.val);
        end
        check("data_done_cycle", cyc, e.due);
      end
    end
  end

  task automatic access(input bit is_data, input bit we, input logic [1:0] size, input bit uns,
                        input int addr, input logic [31:0] wd, input int stall_at,
                        input int stall_len);
    exp_t e;
    int   c, n, rel;
    bit   seen, st;
    @(negedge clk);
    c  = cyc;
    st = is_data && we;
    n  = is_data ? nbytes(size) : 4;
    e.we   = st;
    e.n    = n;
    e.addr = addr;
    e.due  = c + (st ? n + 1 : n + 2) + stall_len;
    if (st) begin
      e.val = wd;
      for (int i = 0; i < n; i++) ref_mem[wrap(addr + i)] = wd[8*i +: 8];
    end else begin
      e.val = model_load(!is_data, size, uns, addr);
    end
    if (is_data) begin
      dq.push_back(e);
      data_we = we; data_size = size; data_unsigned = uns;
      data_addr = AW'(addr); data_wdata = wd; data_req = 1'b1;
    end else begin
      if_q.push_back(e);
      if_addr = AW'(addr); if_req = 1'b1;
    end
    seen = 1'b0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      rel = cyc - c;
      if (stall_len > 0 && rel == stall_at) rdy_in = 1'b0;
      if (stall_len > 0 && rel == stall_at + stall_len) rdy_in = 1'b1;
      if (stall_len > 0 && rel >= stall_at && rel < stall_at + stall_len) begin
        #1;
        check("stall_mem_wr", 32'(mem_wr), 32'(0));
        check("stall_mem_a", 32'(mem_a), 32'(wrap(addr + stall_at - 1)));
      end
      if (stall_len == 0 && rel <= n) begin
        check("mem_a", 32'(mem_a), 32'(wrap(addr + rel - 1)));
        check("mem_wr", 32'(mem_wr), 32'(st));
        if (st) check("mem_dout", 32'(mem_dout), 32'(wd[8*(rel-1) +: 8]));
      end
      check("busy", 32'(busy), 32'(cyc < e.due));
      if ((is_data && data_done === 1'b1) || (!is_data && if_done === 1'b1)) seen = 1'b1;
    end
    if (is_data) data_req = 1'b0;
    else if_req = 1'b0;
    check("access_done_seen", 32'(seen), 32'(1));
    if (!seen) begin
      if_q.delete();
      dq.delete();
    end
  endtask

  // Both requesters raise req in the same cycle; the loser waits out the bubble.
  task automatic contest(input bit if_first, input int daddr, input int iaddr);
    exp_t ed, ei;
    int   c;
    bit   sd, si;
    @(negedge clk);
    c = cyc;
    ed.we = 1'b0; ed.n = 4; ed.addr = daddr; ed.val = model_load(1'b0, 2'b10, 1'b1, daddr);
    ei.we = 1'b0; ei.n = 4; ei.addr = iaddr; ei.val = model_load(1'b1, 2'b10, 1'b0, iaddr);
    ed.due = if_first ? c + 13 : c + 6;
    ei.due = if_first ? c + 6 : c + 13;
    dq.push_back(ed);
    if_q.push_back(ei);
    data_we = 1'b0; data_size = 2'b10; data_unsigned = 1'b1; data_addr = AW'(daddr);
    data_req = 1'b1;
    if_addr = AW'(iaddr);
    if_req = 1'b1;
    sd = 1'b0;
    si = 1'b0;
    for (int k = 0; k < 80 && !(sd && si); k++) begin
      @(negedge clk);
      if (data_done === 1'b1) begin sd = 1'b1; data_req = 1'b0; end
      if (if_done === 1'b1) begin si = 1'b1; if_req = 1'b0; end
    end
    data_req = 1'b0;
    if_req = 1'b0;
    check("contest_data_done", 32'(sd), 32'(1));
    check("contest_if_done", 32'(si), 32'(1));
    if (!(sd && si)) begin
      if_q.delete();
      dq.delete();
    end
  endtask

  // Reset lands at the end of cycle 2 of a word store: two bytes are already written.
  task automatic reset_mid_store(input int addr, input logic [31:0] wd);
    @(negedge clk);
    data_we = 1'b1; data_size = 2'b10; data_unsigned = 1'b0;
    data_addr = AW'(addr); data_wdata = wd; data_req = 1'b1;
    ref_mem[wrap(addr)]     = wd[7:0];
    ref_mem[wrap(addr + 1)] = wd[15:8];
    @(negedge clk);
    check("rst_store_c1_wr", 32'(mem_wr), 32'(1));
    @(negedge clk);
    check("rst_store_c2_a", 32'(mem_a), 32'(wrap(addr + 1)));
    rst = 1'b1;
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mem_wr", 32'(mem_wr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_data_rdata", data_rdata, 32'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_done", 32'(data_done), 32'(0));
      check("rst_idle_wr", 32'(mem_wr), 32'(0));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    rst = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_size = 2'b00; data_unsigned = 1'b0;
    data_addr = '0; data_wdata = '0;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      mem[i] <= b;
      ref_mem[i] = b;
    end
    mem['h10] <= 8'h13; ref_mem['h10] = 8'h13;
    mem['h11] <= 8'h05; ref_mem['h11] = 8'h05;
    mem['h12] <= 8'h00; ref_mem['h12] = 8'h00;
    mem['h13] <= 8'h00; ref_mem['h13] = 8'h00;
    mem['h100] <= 8'h80; ref_mem['h100] = 8'h80;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_if_done", 32'(if_done), 32'(0));
    check("reset_data_done", 32'(data_done), 32'(0));
    check("reset_if_inst", if_inst, 32'(0));
    check("reset_data_rdata", data_rdata, 32'(0));
    check("reset_mem_a", 32'(mem_a), 32'(0));
    check("reset_mem_dout", 32'(mem_dout), 32'(0));
    check("reset_mem_wr", 32'(mem_wr), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));

    access(1'b0, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 0, 0);              // fetch 0x00000513
    access(1'b1, 1'b0, 2'b00, 1'b0, 'h100, 32'h0, 0, 0);             // lb  -> FFFFFF80
    access(1'b1, 1'b0, 2'b00, 1'b1, 'h100, 32'h0, 0, 0);             // lbu -> 00000080
    access(1'b1, 1'b1, 2'b10, 1'b0, 'h1FFFE, 32'hDEADBEEF, 0, 0);    // sw wrapping
    access(1'b1, 1'b0, 2'b10, 1'b1, 'h1FFFE, 32'h0, 0, 0);
    access(1'b1, 1'b1, 2'b00, 1'b0, 'h200, 32'h123456A5, 0, 0);      // sb
    access(1'b1, 1'b1, 2'b01, 1'b0, 'h1FFFF, 32'h0000F00D, 0, 0);    // sh wrapping
    access(1'b1, 1'b0, 2'b01, 1'b0, 'h1FFFF, 32'h0, 0, 0);           // lh -> FFFFF00D
    access(1'b1, 1'b0, 2'b11, 1'b0, 'h1FFFF, 32'h0, 0, 0);           // size 11 = word

    contest(1'b0, 'h300, 'h400);
`ifdef MEM_CTRL_FAIR_EN
    contest(1'b1, 'h500, 'h600);
`else
    contest(1'b0, 'h500, 'h600);
`endif

    access(1'b0, 1'b0, 2'b10, 1'b0, 'h700, 32'h0, 4, 3);             // stall mid fetch
    access(1'b1, 1'b1, 2'b10, 1'b0, 'h800, 32'hA5C3_3C5A, 2, 2);     // stall mid store
    access(1'b1, 1'b0, 2'b10, 1'b0, 'h800, 32'h0, 0, 0);

    reset_mid_store('h900, 32'hCAFEF00D);
    access(1'b1, 1'b0, 2'b10, 1'b0, 'h900, 32'h0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, MSZ - 1)), $urandom, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("queues_drained", 32'(if_q.size() + dq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
